// File: rtl/ibuf_pkg.sv
// Shared definitions for the banked input-buffer read/write controllers.
// Address widths, FSM state type and buffer-geometry helper functions.
package ibuf_pkg;

   localparam int unsigned ROW_W = 8;
   localparam int unsigned COL_W = 28;

   localparam logic [1:0] CREDIT_MAX = 2'd2;

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StRel
   } ibuf_state_e;

   // Row length needed to cover POX outputs with a KSIZE window at the given stride.
   function automatic int unsigned calc_ral(int unsigned pox, int unsigned stride,
                                            int unsigned ksize);
      return (pox - 1) * stride + ksize;
   endfunction

   function automatic int unsigned calc_bufh(int unsigned stride);
      return 2 * stride;
   endfunction

   function automatic int unsigned calc_bufw(int unsigned burst);
      return burst;
   endfunction

endpackage

// File: rtl/ibuf_credit_cnt.sv
// Saturating 0..2 credit counter for half-buffer hand-off between writer and reader.
// Simultaneous inc and dec leave the count unchanged.
module ibuf_credit_cnt
   import ibuf_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic       inc,
   input  logic       dec,
   output logic [1:0] count
);

   logic [1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && !dec) begin
         if (count_q != CREDIT_MAX) count_d = count_q + 2'd1;
      end else if (dec && !inc) begin
         if (count_q != 2'd0) count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/ibuf_reader.sv
// Read-side controller of the banked input buffer: walks one half-buffer per credit.
// Optional sticky overflow/underrun flag 'err' when IBUF_READER_CHECK_EN is defined.
module ibuf_reader
   import ibuf_pkg::*;
#(
   parameter int unsigned DW     = 32,
   parameter int unsigned STRIDE = 1,
   parameter int unsigned KSIZE  = 3,
   parameter int unsigned POX    = 16,
   parameter int unsigned POY    = 3,
   parameter int unsigned BURST  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              data_load,
   input  logic              fill_done,
   input  logic              rd_req,
   output logic [ROW_W-1:0]  rrow,
   output logic [COL_W-1:0]  rcol,
   output logic              ren,
   input  logic [POY*DW-1:0] bank_rdata,
   output logic [POY*DW-1:0] odata,
   output logic              ovalid,
   output logic              half_release,
   output logic [1:0]        credit
`ifdef IBUF_READER_CHECK_EN
   ,
   output logic              err
`endif
);

   localparam int unsigned RAL  = calc_ral(POX, STRIDE, KSIZE);
   localparam int unsigned BUFH = calc_bufh(STRIDE);
   localparam int unsigned BUFW = calc_bufw(BURST);

   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(RAL - 1);
   localparam logic [ROW_W-1:0] BIAS_LAST = ROW_W'(STRIDE - 1);
   localparam logic [ROW_W-1:0] BASE_LAST = ROW_W'(BUFH - STRIDE);
   localparam logic [ROW_W-1:0] STRIDE_R  = ROW_W'(STRIDE);

   if (RAL > BUFW) begin : g_bad_cfg
      $error("ibuf_reader: RAL exceeds physical buffer row length");
   end

   ibuf_state_e      state_q, state_d;
   logic             half_q, half_d;
   logic [ROW_W-1:0] row_base_q, row_base_d;
   logic [ROW_W-1:0] row_bias_q, row_bias_d;
   logic [COL_W-1:0] rcol_q, rcol_d;
   logic             ren_d1_q;
   logic             clr;

   // Dropping data_load aborts the layer exactly like a reset.
   assign clr = rst | ~data_load;

   ibuf_credit_cnt u_credit (
      .clk   (clk),
      .clr   (clr),
      .inc   (fill_done),
      .dec   (half_release),
      .count (credit)
   );

   always_comb begin
      state_d      = state_q;
      half_d       = half_q;
      row_base_d   = row_base_q;
      row_bias_d   = row_bias_q;
      rcol_d       = rcol_q;
      ren          = 1'b0;
      half_release = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (credit != 2'd0) begin
               state_d    = StRead;
               row_base_d = half_q ? STRIDE_R : '0;
               row_bias_d = '0;
               rcol_d     = '0;
            end
         end
         StRead: begin
            ren = rd_req;
            if (rd_req) begin
               if (rcol_q == COL_LAST) begin
                  rcol_d = '0;
                  if (row_bias_q == BIAS_LAST) begin
                     row_bias_d = '0;
                     state_d    = StRel;
                  end else begin
                     row_bias_d = row_bias_q + ROW_W'(1);
                  end
               end else begin
                  rcol_d = rcol_q + COL_W'(1);
               end
            end
         end
         StRel: begin
            half_release = 1'b1;
            half_d       = ~half_q;
            row_base_d   = (row_base_q == BASE_LAST) ? '0 : row_base_q + STRIDE_R;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q    <= StIdle;
         half_q     <= 1'b0;
         row_base_q <= '0;
         row_bias_q <= '0;
         rcol_q     <= '0;
         ren_d1_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         half_q     <= half_d;
         row_base_q <= row_base_d;
         row_bias_q <= row_bias_d;
         rcol_q     <= rcol_d;
         ren_d1_q   <= ren;
      end
   end

   assign rrow = row_base_q + row_bias_q;
   assign rcol = rcol_q;

   // A beat already issued to the banks still lands when data_load drops; rst kills it.
   always_ff @(posedge clk) begin
      if (rst) begin
         odata  <= '0;
         ovalid <= 1'b0;
      end else if (!data_load) begin
         odata  <= ren_d1_q ? bank_rdata : '0;
         ovalid <= ren_d1_q;
      end else begin
         odata  <= bank_rdata;
         ovalid <= ren_d1_q;
      end
   end

`ifdef IBUF_READER_CHECK_EN
   logic overflow, underrun;

   assign overflow = fill_done & ~half_release & (credit == CREDIT_MAX);
   assign underrun = rd_req & (state_q == StIdle) & (credit == 2'd0);

   always_ff @(posedge clk) begin
      if (clr)                       err <= 1'b0;
      else if (overflow || underrun) err <= 1'b1;
   end
`endif

endmodule

// File: doc/ibuf_reader.md
Name: ibuf_reader

Overview:
- Read-side controller of the banked input buffer.
- Consumes one buffer half (STRIDE rows × RAL columns in each of POY banks) at a time, issuing a common row/column address to all POY banks in parallel.
- Returns the bank read data to the PE array one cycle later.
- Tracks half-buffer occupancy with credits: one credit arrives per half filled by the write side, and one credit is released per half consumed.

Parameters:
- DW, 32, data width per bank.
- STRIDE, 1, convolution stride; rows per half-buffer.
- KSIZE, 3, kernel size.
- POX, 16, output-column parallelism.
- POY, 3, number of banks (output-row parallelism).
- BURST, 32, physical buffer row length (BUFW). Must satisfy RAL <= BURST.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- data_load  in  1  layer-active qualifier. Low clears all counters and credits, same as rst.
- fill_done  in  1  one-cycle pulse from write side: one half-buffer completely written.
- rd_req  in  1  downstream requests the next address beat.
- rrow  out  8  read row address, common to all banks.
- rcol  out  28  read column address, common to all banks.
- ren  out  1  bank read enable.
- bank_rdata  in  POY*DW  bank read data, valid one cycle after ren.
- odata  out  POY*DW  registered output data.
- ovalid  out  1  odata valid.
- release  out  1  one-cycle pulse: a half-buffer has been consumed and may be overwritten.
- credit  out  2  halves currently readable (0..2).

Behaviour:
- Local constants:
  - RAL = (POX-1)*STRIDE + KSIZE.
  - BUFH = 2*STRIDE.
- Reset (rst=1 or data_load=0), applied on the next edge:
  - All outputs 0: rrow, rcol, ren, ovalid, release, credit, odata.
  - State = IDLE, half = 0.
- Credit counter:
  - +1 on fill_done; -1 on the release pulse.
  - Simultaneous fill_done and release: credit unchanged.
  - fill_done while credit = 2 and no release in the same cycle: increment ignored, credit saturates at 2.
- FSM states: IDLE, READ, REL.
  - IDLE -> READ when credit > 0. Loads row_base = half*STRIDE, row_bias = 0, rcol = 0.
  - READ:
    - ren = rd_req. rrow = row_base + row_bias.
    - Address advances only on cycles with ren = 1. When ren = 0, the address is held; no beat is skipped or repeated.
    - rcol counts 0..RAL-1. On wrap, rcol returns to 0 and row_bias increments.
    - When the beat with row_bias = STRIDE-1 and rcol = RAL-1 is issued: go to REL.
  - REL (exactly 1 cycle): release = 1, half toggles (row_base wraps BUFH-STRIDE -> 0), next state IDLE.
    - Back-to-back halves therefore cost one REL cycle plus one IDLE cycle.
- Data path:
  - odata <= bank_rdata and ovalid <= ren_d1, where ren_d1 is ren delayed one cycle.
  - Read latency is two cycles from rd_req to ovalid; address goes out in the same cycle as rd_req.
  - No backpressure on the data path.
- Beats per half = STRIDE*RAL. Address order: row-major, column fastest.
- data_load falling mid-READ: abort immediately, no release pulse, all state cleared. An in-flight ovalid still completes on the next cycle.

Optional Feature:
- Macro: IBUF_READER_CHECK_EN.
- Defined:
  - Extra output err (1 bit), sticky until rst or data_load=0.
  - Set on fill_done with credit = 2 and no release in the same cycle (overflow).
  - Set on rd_req while in IDLE with credit = 0 (underrun).
- Not defined: port absent. Overflow saturates silently; rd_req in IDLE is ignored.

Decomposition:
- Shared package ibuf_pkg holds:
  - Localparam functions for RAL, BUFH, BUFW.
  - Address widths (ROW_W = 8, COL_W = 28).
  - FSM state enum typedef (IDLE/READ/REL).
- Sub-module ibuf_credit_cnt: saturating 2-bit up/down counter with simultaneous inc/dec handling. Instantiated once; reused by the writer side later.

Test Plan:
- Defaults (STRIDE=1, RAL=18): one fill_done, rd_req held high.
  -> 18 beats, rrow = 0, rcol = 0..17; release one cycle after the last beat; credit 1 -> 0; ovalid runs 18 cycles, delayed 2 from the first rd_req.
- STRIDE=2 (RAL=33, BURST=64): two fill_done pulses.
  -> half 0 reads rows 0,1 then release; half 1 reads rows 2,3 then release; third half returns to rows 0,1.
- rd_req toggling 1,0,1,0 during READ.
  -> rcol advances only on rd_req = 1; 18 total beats; no repeats or gaps.
- fill_done coinciding with the release cycle at credit = 1.
  -> credit stays 1 and the next half starts; fill_done at credit = 2 -> credit stays 2, err = 1 (with macro defined).
- data_load dropped at rcol = 7.
  -> next cycle: state IDLE, credit 0, rrow/rcol = 0, no release pulse; restart from rcol = 0 after a new fill_done.
- rst asserted mid-READ at the same time as fill_done.
  -> all outputs 0 next cycle, credit 0.
